// File: rtl/mem_access_unit.sv
// MEM stage of the 5-stage MIPS core: variable-latency data memory access over a req/ack handshake, with front-pipeline stall and MEM/WB registers.
// Optional stall_cycles counter output when MEM_STALL_CNT_EN is defined.
module mem_access_unit #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemtoReg_mem,
    input  logic        RegWrite_mem,
    input  logic        MemWrite_mem,
    input  logic [31:0] ALUResult_mem,
    input  logic [31:0] MemWriteData_mem,
    input  logic [4:0]  rdAddr_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_mem,
    output logic        MemtoReg_wb,
    output logic        RegWrite_wb,
    output logic [31:0] ReadData_wb,
    output logic [31:0] ALUResult_wb,
    output logic [4:0]  rdAddr_wb,
    output logic        misalign_err,
`ifdef MEM_STALL_CNT_EN
    output logic [31:0] stall_cycles,
`endif
    output logic        bus_err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              access, aligned;
    logic              req_c, stall_c;
    logic              wb_load, wb_regwrite, set_misalign, set_bus_err;
    logic [31:0]       wb_rdata;

    assign access  = MemtoReg_mem | MemWrite_mem;
    assign aligned = (ALUResult_mem[1:0] == 2'b00);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        req_c        = 1'b0;
        stall_c      = 1'b0;
        wb_load      = 1'b0;
        wb_regwrite  = 1'b0;
        wb_rdata     = 32'd0;
        set_misalign = 1'b0;
        set_bus_err  = 1'b0;
        case (state)
            IDLE: begin
                if (access && aligned) begin
                    req_c     = 1'b1;
                    stall_c   = 1'b1;
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end else begin
                    // Misaligned accesses retire without touching memory or the register file.
                    wb_load      = 1'b1;
                    wb_regwrite  = RegWrite_mem & ~access;
                    set_misalign = access;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    req_c       = 1'b1;
                    wb_load     = 1'b1;
                    wb_regwrite = RegWrite_mem & ~MemWrite_mem;
                    wb_rdata    = MemtoReg_mem ? dmem_rdata : 32'd0;
                    state_nxt   = IDLE;
                end else if (cnt == CNT_LAST) begin
                    wb_load     = 1'b1;
                    wb_rdata    = ERR_DATA;
                    set_bus_err = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and stall are suppressed while reset is held so a reset mid-WAIT drops them at once.
    assign dmem_req   = req_c & ~rst;
    assign stall_mem  = stall_c & ~rst;
    assign dmem_we    = MemWrite_mem & dmem_req;
    assign dmem_addr  = {ALUResult_mem[31:2], 2'b00};
    assign dmem_wdata = MemWriteData_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MemtoReg_wb  <= 1'b0;
            RegWrite_wb  <= 1'b0;
            ReadData_wb  <= 32'd0;
            ALUResult_wb <= 32'd0;
            rdAddr_wb    <= 5'd0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= set_misalign;
            if (set_bus_err)
                bus_err <= 1'b1;
            if (wb_load) begin
                MemtoReg_wb  <= MemtoReg_mem;
                RegWrite_wb  <= wb_regwrite;
                ReadData_wb  <= wb_rdata;
                ALUResult_wb <= ALUResult_mem;
                rdAddr_wb    <= rdAddr_mem;
            end
        end
    end

`ifdef MEM_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= 32'd0;
        else if (stall_mem)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: non-memory ops, load/store handshakes,
// misalignment, timeout, ack racing timeout and reset during an outstanding access.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemtoReg_mem, RegWrite_mem, MemWrite_mem;
    logic [31:0] ALUResult_mem, MemWriteData_mem;
    logic [4:0]  rdAddr_mem;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall_mem, MemtoReg_wb, RegWrite_wb;
    logic [31:0] ReadData_wb, ALUResult_wb;
    logic [4:0]  rdAddr_wb;
    logic        misalign_err, bus_err;
`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem), .MemWrite_mem(MemWrite_mem),
        .ALUResult_mem(ALUResult_mem), .MemWriteData_mem(MemWriteData_mem), .rdAddr_mem(rdAddr_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_mem(stall_mem),
        .MemtoReg_wb(MemtoReg_wb), .RegWrite_wb(RegWrite_wb), .ReadData_wb(ReadData_wb),
        .ALUResult_wb(ALUResult_wb), .rdAddr_wb(rdAddr_wb), .misalign_err(misalign_err),
`ifdef MEM_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic mtr, input logic rw, input logic mw,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
        MemtoReg_mem     = mtr;
        RegWrite_mem     = rw;
        MemWrite_mem     = mw;
        ALUResult_mem    = alu;
        MemWriteData_mem = wd;
        rdAddr_mem       = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Caller has just applied an aligned access; ack arrives n cycles after req first rises.
    task automatic run_access(input string tag, input int n, input logic [31:0] rdata,
                              input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        for (int i = 0; i <= n; i++) begin
            if (i == n) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            #1;
            chk({tag, "_req"}, 32'(dmem_req), 32'd1);
            chk({tag, "_stall"}, 32'(stall_mem), 32'(i < n));
            if (i == 0 || i == n) begin
                chk({tag, "_addr"}, dmem_addr, addr);
                chk({tag, "_we"}, 32'(dmem_we), 32'(we));
                if (we)
                    chk({tag, "_wdata"}, dmem_wdata, wdata);
            end
            @(posedge clk);
            #1;
            dmem_ack   = 1'b0;
            dmem_rdata = 32'd0;
        end
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        set_op(0, 0, 0, 32'd0, 32'd0, 5'd0);
        #3;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall_mem), 32'd0);
        chk("rst_regwrite", 32'(RegWrite_wb), 32'd0);
        chk("rst_rdata", ReadData_wb, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Non-memory op
        set_op(0, 1, 0, 32'h5, 32'd0, 5'd3);
        #1;
        chk("alu_stall", 32'(stall_mem), 32'd0);
        chk("alu_req", 32'(dmem_req), 32'd0);
        next_cycle();
        chk("alu_result", ALUResult_wb, 32'h5);
        chk("alu_rd", 32'(rdAddr_wb), 32'd3);
        chk("alu_regwrite", 32'(RegWrite_wb), 32'd1);
        chk("alu_rdata", ReadData_wb, 32'd0);
        chk("alu_stall_after", 32'(stall_mem), 32'd0);

        // Load, ack 3 cycles after req
        set_op(1, 1, 0, 32'h40, 32'd0, 5'd7);
        run_access("ld40", 3, 32'h1234, 32'h40, 1'b0, 32'd0);
        chk("ld40_data", ReadData_wb, 32'h1234);
        chk("ld40_mtr", 32'(MemtoReg_wb), 32'd1);
        chk("ld40_regwrite", 32'(RegWrite_wb), 32'd1);
        chk("ld40_rd", 32'(rdAddr_wb), 32'd7);

        // Store followed immediately by a load of the same word
        set_op(0, 0, 1, 32'h44, 32'hA5A5, 5'd0);
        run_access("st44", 2, 32'hFFFF_FFFF, 32'h44, 1'b1, 32'hA5A5);
        chk("st44_regwrite", 32'(RegWrite_wb), 32'd0);
        chk("st44_rdata", ReadData_wb, 32'd0);
        chk("st44_mtr", 32'(MemtoReg_wb), 32'd0);
        set_op(1, 1, 0, 32'h44, 32'd0, 5'd8);
        run_access("ld44", 1, 32'hA5A5, 32'h44, 1'b0, 32'd0);
        chk("ld44_data", ReadData_wb, 32'hA5A5);
        chk("ld44_rd", 32'(rdAddr_wb), 32'd8);

        // Misaligned load
        set_op(1, 1, 0, 32'h42, 32'd0, 5'd5);
        #1;
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(stall_mem), 32'd0);
        next_cycle();
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_regwrite", 32'(RegWrite_wb), 32'd0);
        chk("mis_alu", ALUResult_wb, 32'h42);
        set_op(0, 0, 0, 32'd0, 32'd0, 5'd0);
        next_cycle();
        chk("mis_pulse_end", 32'(misalign_err), 32'd0);

        // Ack in the same cycle as the timeout: ack wins
        set_op(1, 1, 0, 32'h84, 32'd0, 5'd9);
        run_access("race", 16, 32'h55AA, 32'h84, 1'b0, 32'd0);
        chk("race_data", ReadData_wb, 32'h55AA);
        chk("race_regwrite", 32'(RegWrite_wb), 32'd1);
        chk("race_bus_err", 32'(bus_err), 32'd0);

        // Load that is never acknowledged
        set_op(1, 1, 0, 32'h80, 32'd0, 5'd10);
        n = 0;
        #1;
        while (dmem_req && n < 40) begin
            n++;
            next_cycle();
        end
        chk("to_req_cycles", 32'(n), 32'd16);
        chk("to_stall_drop", 32'(stall_mem), 32'd0);
        next_cycle();
        chk("to_data", ReadData_wb, 32'hDEADBEEF);
        chk("to_regwrite", 32'(RegWrite_wb), 32'd0);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        set_op(0, 1, 0, 32'h11, 32'd0, 5'd1);
        next_cycle();
        next_cycle();
        chk("to_bus_err_sticky", 32'(bus_err), 32'd1);
        rst = 1'b1;
        #1;
        chk("to_bus_err_rst", 32'(bus_err), 32'd0);
        next_cycle();
        rst = 1'b0;
        set_op(0, 1, 0, 32'h22, 32'd0, 5'd2);
        next_cycle();
        chk("post_rst_alu", ALUResult_wb, 32'h22);

        // Reset while an access is outstanding
        set_op(1, 1, 0, 32'h88, 32'd0, 5'd4);
        next_cycle();
        next_cycle();
        chk("rw_req_before", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_req", 32'(dmem_req), 32'd0);
        chk("rw_stall", 32'(stall_mem), 32'd0);
        chk("rw_alu_wb", ALUResult_wb, 32'd0);
        chk("rw_rd_wb", 32'(rdAddr_wb), 32'd0);
        chk("rw_regwrite_wb", 32'(RegWrite_wb), 32'd0);
        set_op(0, 0, 0, 32'd0, 32'd0, 5'd0);
        next_cycle();
        rst        = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h7777;
        next_cycle();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        chk("rw_ack_ignored_data", ReadData_wb, 32'd0);
        chk("rw_ack_ignored_mtr", 32'(MemtoReg_wb), 32'd0);
        chk("rw_ack_ignored_req", 32'(dmem_req), 32'd0);
        chk("rw_bus_err", 32'(bus_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
